idli_retire_trace: RTL

IDLI_RETIRE_TRACE -- requirements
Module: idli_retire_trace

---
 rtl/idli_retire_trace.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/idli_retire_trace.sv
// idli_retire_trace: retirement trace for the idli core.
// An instruction's register/predicate writes are gathered into an accumulator
// while i_ctr==0; on the last sync slot (i_ctr all ones) a trace record is
// committed into a small FIFO. The FIFO head is presented on registered
// o_trc_* outputs with a valid/ready pop handshake.
// A commit into a full FIFO with no pop is dropped. The drop is counted in
// o_ovf_cnt, and seq still advances so the gap is visible downstream.
// Optional feature macro: IDLI_RETIRE_TRACE_DATA_EN stores i_wr_data per
// entry and presents it on o_trc_data. Without it, o_trc_data is tied to 0.
module idli_retire_trace #(
  parameter int NUM_REGS = 16,
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int CTR_W    = 2
) (
  input  logic                        gck,
  input  logic                        rst_n,
  input  logic [CTR_W-1:0]            i_ctr,
  input  logic                        i_run_instr,
  input  logic                        i_skip_instr,
  input  logic                        i_dst_reg_wr,
  input  logic [$clog2(NUM_REGS)-1:0] i_dst_reg,
  input  logic                        i_dst_is_pred,
  input  logic [DATA_W-1:0]           i_wr_data,
  input  logic                        i_pred,
  input  logic                        i_clr,
  output logic                        o_trc_vld,
  input  logic                        i_trc_rdy,
  output logic [NUM_REGS-1:0]         o_trc_mask,
  output logic                        o_trc_pred_wr,
  output logic                        o_trc_pred,
  output logic [DATA_W-1:0]           o_trc_data,
  output logic [15:0]                 o_trc_seq,
  output logic [7:0]                  o_ovf_cnt,
  output logic [$clog2(DEPTH):0]      o_level
);

  localparam int REG_W = $clog2(NUM_REGS);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [NUM_REGS-1:0] ONE_MASK  = {{(NUM_REGS-1){1'b0}}, 1'b1};
  localparam logic [LVL_W-1:0]    FULL_LVL  = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]    LVL_ONE   = {{(LVL_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]    PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};

  // Accumulator for the instruction currently in flight
  logic [NUM_REGS-1:0] acc_mask;
  logic                acc_pred_wr;
  logic [15:0]         seq;

  // FIFO storage and bookkeeping
  logic [NUM_REGS-1:0] mem_mask    [DEPTH];
  logic                mem_pred_wr [DEPTH];
  logic                mem_pred    [DEPTH];
  logic [15:0]         mem_seq     [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [LVL_W-1:0]    level;
  logic [7:0]          ovf_cnt;

`ifdef IDLI_RETIRE_TRACE_DATA_EN
  logic [DATA_W-1:0]   mem_data [DEPTH];
  logic [DATA_W-1:0]   head_data;
`else
  wire                 unused_wr_data = ^i_wr_data;
`endif

  // Decoded control
  logic                acc_phase;
  logic                commit;
  logic [NUM_REGS-1:0] mask_set;
  logic                pw_set;
  logic                full;
  logic                empty;
  logic                pop;
  logic                push;
  logic                drop;
  logic [LVL_W-1:0]    level_next;
  logic [LVL_W-1:0]    remain;
  logic [PTR_W-1:0]    rd_adv;

  // Next head record
  logic [NUM_REGS-1:0] head_mask;
  logic                head_pred_wr;
  logic                head_pred;
  logic [15:0]         head_seq;

  // Decode the sync slot, accumulation bits and FIFO handshake for this cycle
  always_comb begin
    acc_phase = (i_ctr == {CTR_W{1'b0}}) && i_run_instr;
    commit    = (i_ctr == {CTR_W{1'b1}}) && i_run_instr;
    if (acc_phase && i_dst_reg_wr && (i_dst_reg != {REG_W{1'b0}})) begin
      mask_set = ONE_MASK << i_dst_reg;
    end else begin
      mask_set = {NUM_REGS{1'b0}};
    end
    pw_set     = acc_phase && i_dst_is_pred;
    full       = (level == FULL_LVL);
    empty      = (level == {LVL_W{1'b0}});
    pop        = !empty && i_trc_rdy;
    push       = commit && (!full || pop);
    drop       = commit && full && !pop;
    remain     = pop ? (level - LVL_ONE) : level;
    level_next = push ? (remain + LVL_ONE) : remain;
    rd_adv     = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
  end

  // Choose what the head register shows after this edge: nothing, the record
  // being committed right now (FIFO otherwise empty), or the stored entry
  always_comb begin
    head_mask    = {NUM_REGS{1'b0}};
    head_pred_wr = 1'b0;
    head_pred    = 1'b0;
    head_seq     = 16'h0000;
`ifdef IDLI_RETIRE_TRACE_DATA_EN
    head_data    = {DATA_W{1'b0}};
`endif
    if (level_next == {LVL_W{1'b0}}) begin
      head_mask = {NUM_REGS{1'b0}};
    end else if (remain == {LVL_W{1'b0}}) begin
      head_mask    = acc_mask;
      head_pred_wr = acc_pred_wr;
      head_pred    = i_pred;
      head_seq     = seq;
`ifdef IDLI_RETIRE_TRACE_DATA_EN
      head_data    = i_wr_data;
`endif
    end else begin
      head_mask    = mem_mask[rd_adv];
      head_pred_wr = mem_pred_wr[rd_adv];
      head_pred    = mem_pred[rd_adv];
      head_seq     = mem_seq[rd_adv];
`ifdef IDLI_RETIRE_TRACE_DATA_EN
      head_data    = mem_data[rd_adv];
`endif
    end
  end

  // Accumulator and sequence number; a commit starts a fresh accumulation
  // that already includes any bits gathered in the commit cycle itself
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      acc_mask    <= {NUM_REGS{1'b0}};
      acc_pred_wr <= 1'b0;
      seq         <= 16'h0000;
    end else if (i_clr) begin
      acc_mask    <= {NUM_REGS{1'b0}};
      acc_pred_wr <= 1'b0;
      seq         <= 16'h0000;
    end else if (commit) begin
      acc_mask    <= mask_set;
      acc_pred_wr <= pw_set ? !i_skip_instr : 1'b0;
      seq         <= seq + 16'h0001;
    end else begin
      acc_mask    <= acc_mask | mask_set;
      acc_pred_wr <= pw_set ? !i_skip_instr : acc_pred_wr;
      seq         <= seq;
    end
  end

  // FIFO pointers, occupancy and saturating overflow counter
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= {PTR_W{1'b0}};
      rd_ptr  <= {PTR_W{1'b0}};
      level   <= {LVL_W{1'b0}};
      ovf_cnt <= 8'h00;
    end else if (i_clr) begin
      wr_ptr  <= {PTR_W{1'b0}};
      rd_ptr  <= {PTR_W{1'b0}};
      level   <= {LVL_W{1'b0}};
      ovf_cnt <= 8'h00;
    end else begin
      wr_ptr  <= push ? (wr_ptr + PTR_ONE) : wr_ptr;
      rd_ptr  <= rd_adv;
      level   <= level_next;
      if (drop && (ovf_cnt != 8'hFF)) begin
        ovf_cnt <= ovf_cnt + 8'h01;
      end else begin
        ovf_cnt <= ovf_cnt;
      end
    end
  end

  // Entry storage; contents beyond the occupancy are don't-care
  always_ff @(posedge gck) begin
    if (push && !i_clr) begin
      mem_mask[wr_ptr]    <= acc_mask;
      mem_pred_wr[wr_ptr] <= acc_pred_wr;
      mem_pred[wr_ptr]    <= i_pred;
      mem_seq[wr_ptr]     <= seq;
`ifdef IDLI_RETIRE_TRACE_DATA_EN
      mem_data[wr_ptr]    <= i_wr_data;
`endif
    end else begin
      mem_seq[wr_ptr]     <= mem_seq[wr_ptr];
    end
  end

  // Registered head record and handshake outputs
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      o_trc_vld     <= 1'b0;
      o_trc_mask    <= {NUM_REGS{1'b0}};
      o_trc_pred_wr <= 1'b0;
      o_trc_pred    <= 1'b0;
      o_trc_seq     <= 16'h0000;
    end else if (i_clr) begin
      o_trc_vld     <= 1'b0;
      o_trc_mask    <= {NUM_REGS{1'b0}};
      o_trc_pred_wr <= 1'b0;
      o_trc_pred    <= 1'b0;
      o_trc_seq     <= 16'h0000;
    end else begin
      o_trc_vld     <= (level_next != {LVL_W{1'b0}});
      o_trc_mask    <= head_mask;
      o_trc_pred_wr <= head_pred_wr;
      o_trc_pred    <= head_pred;
      o_trc_seq     <= head_seq;
    end
  end

`ifdef IDLI_RETIRE_TRACE_DATA_EN
  // Registered head data
  always_ff @(posedge gck or negedge rst_n) begin
    if (!rst_n) begin
      o_trc_data <= {DATA_W{1'b0}};
    end else if (i_clr) begin
      o_trc_data <= {DATA_W{1'b0}};
    end else begin
      o_trc_data <= head_data;
    end
  end
`else
  assign o_trc_data = {DATA_W{1'b0}};
`endif

  assign o_level   = level;
  assign o_ovf_cnt = ovf_cnt;

endmodule
